// File: rtl/axi_rab_pkg.sv
// Shared RAB definitions: AXI response codes, B-merge FSM state encoding and
// arbiter grant encoding.
package axi_rab_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    B_MERGE_IDLE     = 2'd0,
    B_MERGE_LOCK_INJ = 2'd1,
    B_MERGE_LOCK_FWD = 2'd2
  } b_merge_state_t;

  // Plain-vector aliases of the enum for legacy code that carries state as logic
  localparam logic [1:0] ST_IDLE     = B_MERGE_IDLE;
  localparam logic [1:0] ST_LOCK_INJ = B_MERGE_LOCK_INJ;
  localparam logic [1:0] ST_LOCK_FWD = B_MERGE_LOCK_FWD;

  localparam logic GRANT_FWD = 1'b0;
  localparam logic GRANT_INJ = 1'b1;

endpackage

// File: rtl/axi4_drop_fifo.sv
// In-order queue of dropped write transactions; pointer based, DEPTH must be a
// power of two so the pointers wrap naturally.
module axi4_drop_fifo #(
  parameter int DATA_WIDTH = 11,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi4_b_resp_merger.sv
// Merges forwarded master-port B responses with locally injected responses for
// dropped writes. Define AXI4_B_RESP_FAIR_ARB_EN for alternating arbitration.
module axi4_b_resp_merger
  import axi_rab_pkg::*;
#(
  parameter int         AXI_ID_WIDTH   = 10,
  parameter int         AXI_USER_WIDTH = 4,
  parameter int         DROP_DEPTH     = 4,
  parameter logic [1:0] ERR_RESP       = AXI_RESP_SLVERR
) (
  input  logic                            axi4_aclk,
  input  logic                            axi4_arstn,
  input  logic [AXI_ID_WIDTH-1:0]         trans_id,
  input  logic                            trans_prefetch,
  input  logic                            trans_drop,
  output logic                            trans_ready,
  input  logic                            wlast_drop,
  output logic [AXI_ID_WIDTH-1:0]         s_axi4_bid,
  output logic [1:0]                      s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0]       s_axi4_buser,
  output logic                            s_axi4_bvalid,
  input  logic                            s_axi4_bready,
  input  logic [AXI_ID_WIDTH-1:0]         m_axi4_bid,
  input  logic [1:0]                      m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0]       m_axi4_buser,
  input  logic                            m_axi4_bvalid,
  output logic                            m_axi4_bready,
  output logic [$clog2(DROP_DEPTH+1)-1:0] drop_count,
  output logic                            response_sent,
  output logic                            credit_err
);

  localparam int CW = $clog2(DROP_DEPTH+1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  credit_err_q, credit_err_d;
  logic [AXI_ID_WIDTH:0] head_data;
  logic                  fifo_full, fifo_empty;
  logic                  inject_ok, favour_inj, grant_inj;
  logic                  inj_hs, wlast_ok;

  axi4_drop_fifo #(
    .DATA_WIDTH(AXI_ID_WIDTH + 1),
    .DEPTH     (DROP_DEPTH)
  ) u_drop_fifo (
    .clk      (axi4_aclk),
    .arstn    (axi4_arstn),
    .push     (trans_drop),
    .push_data({trans_prefetch, trans_id}),
    .pop      (inj_hs),
    .head_data(head_data),
    .count    (drop_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign trans_ready = !fifo_full;
  assign inject_ok   = !fifo_empty && (credits_q != '0);
  assign inj_hs      = grant_inj && s_axi4_bready;
  assign wlast_ok    = wlast_drop && (credits_q != drop_count);

`ifdef AXI4_B_RESP_FAIR_ARB_EN
  logic last_grant_q, last_grant_d;
  logic fwd_hs;

  assign fwd_hs     = !grant_inj && m_axi4_bvalid && s_axi4_bready;
  assign favour_inj = (last_grant_q == GRANT_FWD);

  always_comb begin
    last_grant_d = last_grant_q;
    if (inj_hs)      last_grant_d = GRANT_INJ;
    else if (fwd_hs) last_grant_d = GRANT_FWD;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) last_grant_q <= GRANT_FWD;
    else             last_grant_q <= last_grant_d;
  end
`else
  assign favour_inj = 1'b1;
`endif

  // Grant is combinational in IDLE and pinned while a presented beat is unaccepted
  always_comb begin
    state_d   = state_q;
    grant_inj = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_inj = inject_ok && (favour_inj || !m_axi4_bvalid);
        if (grant_inj && !s_axi4_bready)
          state_d = ST_LOCK_INJ;
        else if (!grant_inj && m_axi4_bvalid && !s_axi4_bready)
          state_d = ST_LOCK_FWD;
      end
      ST_LOCK_INJ: begin
        grant_inj = 1'b1;
        if (s_axi4_bready) state_d = ST_IDLE;
      end
      ST_LOCK_FWD: begin
        if (m_axi4_bvalid && s_axi4_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axi4_bvalid = grant_inj ? 1'b1 : m_axi4_bvalid;
  assign s_axi4_bid    = grant_inj ? head_data[AXI_ID_WIDTH-1:0] : m_axi4_bid;
  assign s_axi4_bresp  = grant_inj ? (head_data[AXI_ID_WIDTH] ? AXI_RESP_OKAY : ERR_RESP)
                                   : m_axi4_bresp;
  assign s_axi4_buser  = grant_inj ? '0 : m_axi4_buser;
  assign m_axi4_bready = grant_inj ? 1'b0 : s_axi4_bready;
  assign response_sent = inj_hs;
  assign credit_err    = credit_err_q;

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (wlast_ok && !inj_hs)      credits_d = credits_q + CW'(1);
    else if (!wlast_ok && inj_hs) credits_d = credits_q - CW'(1);
    // More credits than queued bursts would let an injection outrun its W data
    if (wlast_drop && !wlast_ok)  credit_err_d = 1'b1;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q      <= ST_IDLE;
      credits_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_axi4_b_resp_merger.sv
// Directed self-checking bench for axi4_b_resp_merger (default parameters).
module tb_axi4_b_resp_merger;

  logic       clk = 1'b0;
  logic       arstn;
  logic [9:0] trans_id;
  logic       trans_prefetch, trans_drop, trans_ready, wlast_drop;
  logic [9:0] s_bid, m_bid;
  logic [1:0] s_bresp, m_bresp;
  logic [3:0] s_buser, m_buser;
  logic       s_bvalid, s_bready, m_bvalid, m_bready;
  logic [2:0] drop_count;
  logic       response_sent, credit_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4_b_resp_merger dut (
    .axi4_aclk     (clk),
    .axi4_arstn    (arstn),
    .trans_id      (trans_id),
    .trans_prefetch(trans_prefetch),
    .trans_drop    (trans_drop),
    .trans_ready   (trans_ready),
    .wlast_drop    (wlast_drop),
    .s_axi4_bid    (s_bid),
    .s_axi4_bresp  (s_bresp),
    .s_axi4_buser  (s_buser),
    .s_axi4_bvalid (s_bvalid),
    .s_axi4_bready (s_bready),
    .m_axi4_bid    (m_bid),
    .m_axi4_bresp  (m_bresp),
    .m_axi4_buser  (m_buser),
    .m_axi4_bvalid (m_bvalid),
    .m_axi4_bready (m_bready),
    .drop_count    (drop_count),
    .response_sent (response_sent),
    .credit_err    (credit_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] id, input logic pf);
    trans_id = id; trans_prefetch = pf; trans_drop = 1'b1;
    cyc();
    trans_drop = 1'b0;
  endtask

  task automatic pulse_wlast();
    wlast_drop = 1'b1;
    cyc();
    wlast_drop = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0; trans_id = '0; trans_prefetch = 1'b0; trans_drop = 1'b0;
    wlast_drop = 1'b0; s_bready = 1'b0;
    m_bid = 10'h2A; m_bresp = 2'b11; m_buser = 4'h5; m_bvalid = 1'b1;
    cyc(); #1;
    total++; if (trans_ready !== 1'b1) begin bad++; $display("FAIL reset_trans_ready got=%b exp=1", trans_ready); end
    total++; if (drop_count !== 3'd0) begin bad++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    total++; if (response_sent !== 1'b0 || credit_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", response_sent, credit_err); end
    total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h2A || s_bresp !== 2'b11 || s_buser !== 4'h5)
      begin bad++; $display("FAIL reset_passthrough got=%b/%h/%b/%h exp=1/02a/11/5", s_bvalid, s_bid, s_bresp, s_buser); end
    m_bvalid = 1'b0;
    cyc();
    arstn = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    s_bready = 1'b1;
    push(10'h15, 1'b0); #1;
    total++; if (drop_count !== 3'd1) begin bad++; $display("FAIL single_count_push got=%0d exp=1", drop_count); end
    cyc(); cyc(); cyc(); #1;
    total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL single_no_early_inject got=%b exp=0", s_bvalid); end
    pulse_wlast(); #1;
    total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h15 || s_bresp !== 2'b10 || s_buser !== 4'h0)
      begin bad++; $display("FAIL single_beat got=%b/%h/%b/%h exp=1/015/10/0", s_bvalid, s_bid, s_bresp, s_buser); end
    total++; if (response_sent !== 1'b1 || m_bready !== 1'b0) begin bad++; $display("FAIL single_sent got=%b mbr=%b exp=1/0", response_sent, m_bready); end
    cyc(); #1;
    total++; if (drop_count !== 3'd0 || s_bvalid !== 1'b0 || response_sent !== 1'b0)
      begin bad++; $display("FAIL single_after got=%0d/%b/%b exp=0/0/0", drop_count, s_bvalid, response_sent); end
  endtask

  task automatic test_prefetch();
    push(10'h3, 1'b1);
    pulse_wlast(); #1;
    total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h3 || s_bresp !== 2'b00)
      begin bad++; $display("FAIL prefetch_beat got=%b/%h/%b exp=1/003/00", s_bvalid, s_bid, s_bresp); end
    cyc(); #1;
    total++; if (drop_count !== 3'd0) begin bad++; $display("FAIL prefetch_pop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_full();
    s_bready = 1'b0;
    for (int i = 0; i < 4; i++) push(10'h10 + 10'(i), 1'b0);
    #1;
    total++; if (drop_count !== 3'd4 || trans_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", drop_count, trans_ready); end
    push(10'h14, 1'b0); #1;
    total++; if (drop_count !== 3'd4) begin bad++; $display("FAIL full_refuse got=%0d exp=4", drop_count); end
    for (int i = 0; i < 4; i++) pulse_wlast();
    s_bready = 1'b1; #1;
    total++; if (trans_ready !== 1'b0) begin bad++; $display("FAIL full_pop_no_reopen got=%b exp=0", trans_ready); end
    for (int i = 0; i < 4; i++) begin
      total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h10 + 10'(i) || response_sent !== 1'b1)
        begin bad++; $display("FAIL full_drain_%0d got=%b/%h exp=1/%h", i, s_bvalid, s_bid, 10'h10 + 10'(i)); end
      cyc();
    end
    #1;
    total++; if (drop_count !== 3'd0 || s_bvalid !== 1'b0 || trans_ready !== 1'b1 || credit_err !== 1'b0)
      begin bad++; $display("FAIL full_after got=%0d/%b/%b/%b exp=0/0/1/0", drop_count, s_bvalid, trans_ready, credit_err); end
  endtask

  task automatic test_stability();
    push(10'h21, 1'b0);
    s_bready = 1'b0; m_bid = 10'h7; m_bresp = 2'b00; m_buser = 4'h5; m_bvalid = 1'b1;
    cyc();
    pulse_wlast();
    for (int i = 0; i < 3; i++) begin
      total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h7 || s_buser !== 4'h5)
        begin bad++; $display("FAIL stab_hold_%0d got=%b/%h/%h exp=1/007/5", i, s_bvalid, s_bid, s_buser); end
      cyc();
    end
    s_bready = 1'b1; #1;
    total++; if (s_bid !== 10'h7 || m_bready !== 1'b1) begin bad++; $display("FAIL stab_fwd_hs got=%h/%b exp=007/1", s_bid, m_bready); end
    cyc();
    m_bvalid = 1'b0; #1;
    total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h21 || s_bresp !== 2'b10)
      begin bad++; $display("FAIL stab_inject_after got=%b/%h/%b exp=1/021/10", s_bvalid, s_bid, s_bresp); end
    cyc(); #1;
    total++; if (drop_count !== 3'd0) begin bad++; $display("FAIL stab_pop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_contention();
    logic [9:0] exp_seq [6];
`ifdef AXI4_B_RESP_FAIR_ARB_EN
    exp_seq = '{10'h31, 10'h9, 10'h32, 10'h9, 10'h33, 10'h9};
`else
    exp_seq = '{10'h31, 10'h32, 10'h33, 10'h9, 10'h9, 10'h9};
`endif
    s_bready = 1'b0;
    push(10'h31, 1'b0); push(10'h32, 1'b0); push(10'h33, 1'b0);
    for (int i = 0; i < 3; i++) pulse_wlast();
    m_bid = 10'h9; m_bresp = 2'b00; m_buser = 4'h0; m_bvalid = 1'b1;
    s_bready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++; if (s_bvalid !== 1'b1 || s_bid !== exp_seq[i])
        begin bad++; $display("FAIL contention_beat_%0d got=%b/%h exp=1/%h", i, s_bvalid, s_bid, exp_seq[i]); end
      cyc();
    end
    m_bvalid = 1'b0; #1;
    total++; if (drop_count !== 3'd0 || s_bvalid !== 1'b0) begin bad++; $display("FAIL contention_after got=%0d/%b exp=0/0", drop_count, s_bvalid); end
  endtask

  task automatic test_credit_err();
    pulse_wlast(); #1;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL credit_err_set got=%b exp=1", credit_err); end
    push(10'h44, 1'b0);
    cyc(); cyc(); #1;
    total++; if (s_bvalid !== 1'b0 || drop_count !== 3'd1 || credit_err !== 1'b1)
      begin bad++; $display("FAIL credit_err_no_credit got=%b/%0d/%b exp=0/1/1", s_bvalid, drop_count, credit_err); end
  endtask

  task automatic test_reset_mid();
    s_bready = 1'b0;
    pulse_wlast();
    cyc(); #1;
    total++; if (s_bvalid !== 1'b1 || s_bid !== 10'h44) begin bad++; $display("FAIL rst_mid_locked got=%b/%h exp=1/044", s_bvalid, s_bid); end
    arstn = 1'b0; #1;
    total++; if (drop_count !== 3'd0 || trans_ready !== 1'b1 || credit_err !== 1'b0 || s_bvalid !== 1'b0)
      begin bad++; $display("FAIL rst_mid_cleared got=%0d/%b/%b/%b exp=0/1/0/0", drop_count, trans_ready, credit_err, s_bvalid); end
    cyc();
    arstn = 1'b1;
    cyc(); #1;
    total++; if (s_bvalid !== 1'b0 || drop_count !== 3'd0) begin bad++; $display("FAIL rst_mid_release got=%b/%0d exp=0/0", s_bvalid, drop_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_prefetch();
    test_full();
    test_stability();
    test_contention();
    test_credit_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_b_resp_merger.md
# axi4_b_resp_merger

Generalised write-response merger for the RAB slave port. It combines B responses forwarded from the master port with locally injected responses for write transactions the RAB dropped (miss, protection fault, prefetch). It queues up to DROP_DEPTH dropped transactions and holds each injection until the W sender reports that burst's last beat absorbed. AXI B-channel stability is kept under contention, and the arbitration mode is selectable.

## Interface
Parameters:
- AXI_ID_WIDTH, 10, ID width
- AXI_USER_WIDTH, 4, BUSER width
- DROP_DEPTH, 4, drop-queue entries; power of two, ≥2
- ERR_RESP, 2'b10, BRESP for dropped non-prefetch transactions (SLVERR)

Ports:
- axi4_aclk  in  1  clock
- axi4_arstn  in  1  reset; asynchronous, active-low
- trans_id  in  AXI_ID_WIDTH  ID of dropped transaction
- trans_prefetch  in  1  dropped transaction was a prefetch
- trans_drop  in  1  push request into drop queue
- trans_ready  out  1  drop queue not full; push occurs only on trans_drop & trans_ready
- wlast_drop  in  1  one-cycle pulse: last W beat of oldest unacknowledged dropped burst absorbed
- s_axi4_bid / bresp / buser / bvalid  out  ID/2/USER/1  slave B channel
- s_axi4_bready  in  1
- m_axi4_bid / bresp / buser / bvalid  in  ID/2/USER/1  master B channel
- m_axi4_bready  out  1
- drop_count  out  $clog2(DROP_DEPTH+1)  queued entries
- response_sent  out  1  pulse: injected response handshaked
- credit_err  out  1  sticky: wlast_drop received with credits == drop_count

## Operation
- Drop queue: FIFO of {prefetch, id}, in order. Push when trans_drop & trans_ready. Pop on injected handshake.
- Credit counter, same width as drop_count:
  - wlast_drop increments it.
  - Injected handshake decrements it.
  - Both in the same cycle: unchanged.
  - wlast_drop when credits == drop_count: ignored, credit_err set until reset.
- inject_ok = (drop_count ≠ 0) & (credits ≠ 0).
- Injected beat: bid = head id, buser = 0, bresp = 2'b00 if prefetch else ERR_RESP.
- FSM states IDLE, LOCK_INJ, LOCK_FWD:
  - IDLE: the grant is combinational.
    - Select inject if inject_ok and the arbiter favours inject or m_axi4_bvalid = 0. Otherwise forward.
    - Forwarding passes m_axi4_* to s_axi4_* with m_axi4_bready = s_axi4_bready.
    - If the selected beat is valid but not accepted, go to LOCK_INJ or LOCK_FWD.
  - LOCK_INJ: drive the head entry, m_axi4_bready = 0. On s_axi4_bready return to IDLE.
  - LOCK_FWD: pass through. On m_axi4_bvalid & s_axi4_bready return to IDLE.
- Once s_axi4_bvalid is asserted, id/resp/user stay constant until the handshake.
- Injected handshake: pop, credits−1, response_sent = 1 for one cycle.
- m_axi4_bready is 0 whenever inject is granted.

## Timing
- Reset values:
  - State IDLE, queue empty, credits 0.
  - trans_ready 1, drop_count 0, response_sent 0, credit_err 0.
  - s_axi4_bvalid = m_axi4_bvalid (forward pass-through).
- Push: drop_count updates next cycle. trans_ready = 0 when full. A same-cycle pop does not re-open trans_ready that cycle.
- Injection latency: s_axi4_bvalid rises 1 cycle after the wlast_drop pulse, given an entry is queued. Back-to-back injections are possible every cycle.
- Forward latency: 0 cycles, combinational in IDLE.
- Reset mid-operation clears queue, credits and state. Held beats are abandoned.

## Configuration
- AXI4_B_RESP_FAIR_ARB_EN defined:
  - A 1-bit last_grant register, reset to forward.
  - If inject_ok and m_axi4_bvalid coincide in IDLE, grant the opposite of last_grant.
  - last_grant updates on each handshake.
- Undefined: inject always wins over forward. last_grant is absent.

## Structure
- Shared package axi_rab_pkg: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, state enum b_merge_state_t.
- Sub-module axi4_drop_fifo (DATA_WIDTH, DEPTH) provides the queue: pointer-based with wrap-around, count output.
- FSM, credit counter and arbiter stay in the top level.

## Test plan
- Single drop (id 0x15, non-prefetch), wlast_drop after 3 cycles, s_bready = 1 → one beat bid 0x15, bresp 2'b10, buser 0, response_sent once; drop_count 1→0.
- Prefetch drop id 0x3 → bresp 2'b00.
- Queue full:
  - Push 4 (DROP_DEPTH = 4): trans_ready = 0; a 5th push is refused.
  - Credit and drain all 4 in FIFO order with s_bready = 1 → 4 consecutive beats.
- Stability: m_bvalid with bid 0x7 while s_bready = 0 for 5 cycles, wlast_drop arrives meanwhile → bid stays 0x7 (LOCK_FWD); the injection follows the handshake.
- Contention, both sources continuously valid:
  - Macro on: beats alternate inject/forward.
  - Macro off: all injected beats first.
- Error and reset:
  - wlast_drop with empty queue → credit_err = 1, credits stay 0.
  - Reset asserted mid-LOCK_INJ → drop_count 0, trans_ready 1, credit_err 0.
